// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: alternates ownership on ties, allows bounded locked bursts
// under contention, and returns registered acks and read data one cycle after each access.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        m_memwrite,
  output logic        m_memread,
  output logic [31:0] m_addr,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  state_e      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        ack0_q, ack1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        access0, access1;

  assign gnt0    = (state_q == StOwn0);
  assign gnt1    = (state_q == StOwn1);
  assign access0 = gnt0 && req0;
  assign access1 = gnt1 && req1;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

  always_comb begin
    m_memwrite  = 1'b0;
    m_memread   = 1'b0;
    m_addr      = '0;
    m_writedata = '0;
    if (access0) begin
      m_memwrite  = we0;
      m_memread   = !we0;
      m_addr      = addr0;
      m_writedata = wdata0;
    end else if (access1) begin
      m_memwrite  = we1;
      m_memread   = !we1;
      m_addr      = addr1;
      m_writedata = wdata1;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    if (access0) last_owner_d = 1'b0;
    if (access1) last_owner_d = 1'b1;

    case (state_q)
      StIdle: begin
        burst_cnt_d = '0;
        if (req0 && req1) state_d = last_owner_q ? StOwn0 : StOwn1;
        else if (req0)    state_d = StOwn0;
        else if (req1)    state_d = StOwn1;
      end
      StOwn0: begin
        if (req0 && lock0 && (burst_cnt_q < BurstLast)) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = '0;
          if (req1)      state_d = StOwn1;
          else if (req0) state_d = StOwn0;
          else           state_d = StIdle;
        end
      end
      StOwn1: begin
        if (req1 && lock1 && (burst_cnt_q < BurstLast)) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = '0;
          if (req0)      state_d = StOwn0;
          else if (req1) state_d = StOwn1;
          else           state_d = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      ack0_q       <= access0;
      ack1_q       <= access1;
      if (access0 && !we0) rdata0_q <= m_readdata;
      if (access1 && !we1) rdata1_q <= m_readdata;
    end
  end

endmodule
